alu_exec_unit: RTL
==================

// Module: alu_exec_unit
// PURPOSE
//  Parametrised execute-stage ALU with integrated op decode: ALU_OP/funct3/funct7 -> full RV32I ALU set plus
//  optional M-extension. Base ops: 1-cycle registered. MUL*/DIV*/REM*: iterative, XLEN cycles, via an FSM.
//  Sits between the decode pipeline register and the memory stage; valid/ready on both sides allows stalls.
// PARAMETERS
//  XLEN     32  operand/result width (>=8, power of 2)
//  MEXT_EN  1   1: funct7=0000001 in reg mode runs M-ext ops; 0: such ops decode as ADD
// PORTS
//  clk        in   1     clock, all state on rising edge
//  reset      in   1     synchronous, active-high
//  flush      in   1     kill in-flight/pending op (pipeline redirect)
//  in_valid   in   1     operation offered
//  in_ready   out  1     unit accepts operation this cycle
//  alu_op     in   2     00 ADDR(add), 01 BRANCH(sub), 10 ARITHM_REG, 11 ARITHM_IMM
//  funct3     in   3     instruction funct3
//  funct7     in   7     instruction funct7 (imm mode: only bit5 used, for SRAI)
//  src_a      in   XLEN  operand A
//  src_b      in   XLEN  operand B (already-extended immediate in imm mode)
//  out_valid  out  1     result held valid
//  out_ready  in   1     consumer takes result
//  result     out  XLEN  result
//  zero       out  1     result == 0 (registered with result)
//  busy       out  1     iterative op in progress
// BEHAVIOUR
//  Reset: state IDLE, out_valid=0, result=0, zero=0 (result==0 at reset; zero follows the result==0 rule only
//   once an op completes), busy=0, in_ready=0 during reset cycle.
//  Accept = in_valid & in_ready. in_ready = (state==IDLE) & (!out_valid | out_ready).
//  Decode: ADDR->ADD; BRANCH->SUB; REG f3: 000 ADD/SUB(f7=0100000), 001 SLL, 010 SLT, 011 SLTU, 100 XOR,
//   101 SRL/SRA(f7[5]), 110 OR, 111 AND; IMM same but 000 always ADD, SRAI iff funct7[5]. Unlisted f7 -> f7=0 op.
//  M ops (REG, f7=0000001, MEXT_EN): f3 000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU.
//  Shift amount = src_b[$clog2(XLEN)-1:0]. Add/sub wrap modulo 2^XLEN.
//  Base op: accepted cycle N -> out_valid=1 with result at N+1. No FSM transition.
//  FSM: IDLE -> (accept M op) -> BUSY -> after XLEN iterations -> FIX -> DONE.
//   BUSY: radix-2 shift-add (mul) / restoring (div) on |operands|; counter XLEN-1 down to 0.
//   FIX: apply sign (negate per op signedness), select hi/lo or quotient/remainder.
//   DONE: out_valid=1; on out_ready -> IDLE. busy=1 in BUSY and FIX.
//   Latency M op: accept N -> out_valid at N+XLEN+2.
//  Fast paths (1-cycle, like base ops): divisor 0 -> DIV/DIVU q=all-ones, REM/REMU r=src_a;
//   signed overflow (src_a=MIN, src_b=-1) -> DIV q=MIN, REM r=0.
//  out_valid & !out_ready: result, zero held stable; in_ready=0 only if state!=IDLE, else back-to-back allowed
//   when out_ready=1 (new result replaces old same edge).
//  flush: highest priority after reset; next cycle state=IDLE, out_valid=0, busy=0; op presented with flush
//   is not accepted. Flush in DONE discards result.
//  reset mid-BUSY: identical to reset state next cycle, no partial result emitted.
// TESTING
//  ARITHM_REG f3=000 f7=0100000, a=5 b=7 -> result=0xFFFFFFFE, zero=0, out_valid 1 cycle after accept.
//  ARITHM_IMM f3=101 f7=0100000, a=0x80000000 b=4 -> 0xF8000000; same with f7=0 -> 0x08000000.
//  MULH a=0xFFFFFFFF(-1) b=2 -> 0xFFFFFFFF at accept+34; MULHU same operands -> 0x00000001.
//  DIV a=-7 b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU b=0 -> 0xFFFFFFFF in 1 cycle; DIV 0x80000000/-1 -> 0x80000000.
//  Backpressure: out_ready=0 for 5 cycles after result -> result stable, in_ready=0 in DONE; then drain.
//  flush at BUSY cycle 10 -> out_valid never rises, in_ready=1 next cycle; subsequent ADD 1+1 -> 2 correct.

Source files
------------

// File: rtl/alu_exec_unit_if.sv
// Execute-stage ALU bus: operation offer from decode, result hand-off to memory stage.
// The design is the slave; whoever feeds and drains it is the master.
interface alu_exec_unit_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_op;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            busy;

    modport master (
        output flush, in_valid, alu_op, funct3, funct7, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero, busy
    );

    modport slave (
        input  flush, in_valid, alu_op, funct3, funct7, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero, busy
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: RV32I base ops in one cycle, optional M-extension ops
// computed iteratively (shift-add multiply, restoring divide) over XLEN cycles.
module alu_exec_unit #(
    parameter int unsigned XLEN    = 32,
    parameter bit          MEXT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    alu_exec_unit_if.slave   bus
);
    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned CW  = $clog2(XLEN);
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_e;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_e;

    state_e          state_q;
    logic            out_valid_q;
    logic [XLEN-1:0] result_q;
    logic            zero_q;
    logic            busy_q;

    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] opnd_q;
    logic [CW-1:0]   cnt_q;
    op_e             op_q;
    logic            mul_q;
    logic            neg_q;

    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [SHW-1:0]  shamt;
    op_e             dec_op;
    logic            in_ready_w;
    logic            accept;

    assign a     = bus.src_a;
    assign b     = bus.src_b;
    assign shamt = b[SHW-1:0];

    assign in_ready_w = !reset && (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
    assign accept     = bus.in_valid && in_ready_w && !bus.flush;

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.busy      = busy_q;

    function automatic op_e base_dec(input logic [2:0] f3, input logic sub, input logic sra);
        case (f3)
            3'b000:  return sub ? OP_SUB : OP_ADD;
            3'b001:  return OP_SLL;
            3'b010:  return OP_SLT;
            3'b011:  return OP_SLTU;
            3'b100:  return OP_XOR;
            3'b101:  return sra ? OP_SRA : OP_SRL;
            3'b110:  return OP_OR;
            default: return OP_AND;
        endcase
    endfunction

    // Op decode from alu_op/funct3/funct7
    always_comb begin
        dec_op = OP_ADD;
        case (bus.alu_op)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b10: begin
                if (bus.funct7 == 7'b0000001) begin
                    if (MEXT_EN) begin
                        case (bus.funct3)
                            3'b000:  dec_op = OP_MUL;
                            3'b001:  dec_op = OP_MULH;
                            3'b010:  dec_op = OP_MULHSU;
                            3'b011:  dec_op = OP_MULHU;
                            3'b100:  dec_op = OP_DIV;
                            3'b101:  dec_op = OP_DIVU;
                            3'b110:  dec_op = OP_REM;
                            default: dec_op = OP_REMU;
                        endcase
                    end else begin
                        dec_op = OP_ADD;
                    end
                end else begin
                    dec_op = base_dec(bus.funct3, bus.funct7 == 7'b0100000, bus.funct7[5]);
                end
            end
            default: dec_op = base_dec(bus.funct3, 1'b0, bus.funct7[5]);
        endcase
    end

    logic is_mul;
    logic is_div;
    logic div_zero;
    logic div_ovf;
    logic iter_op;
    logic sgn_a_op;
    logic sgn_b_op;
    logic sa;
    logic sb;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic            neg_start;

    assign is_mul   = (dec_op == OP_MUL) || (dec_op == OP_MULH) ||
                      (dec_op == OP_MULHSU) || (dec_op == OP_MULHU);
    assign is_div   = (dec_op == OP_DIV) || (dec_op == OP_DIVU) ||
                      (dec_op == OP_REM) || (dec_op == OP_REMU);
    assign div_zero = (b == '0);
    assign div_ovf  = ((dec_op == OP_DIV) || (dec_op == OP_REM)) && (a == XMIN) && (b == '1);
    assign iter_op  = is_mul || (is_div && !div_zero && !div_ovf);

    assign sgn_a_op = (dec_op == OP_MULH) || (dec_op == OP_MULHSU) ||
                      (dec_op == OP_DIV) || (dec_op == OP_REM);
    assign sgn_b_op = (dec_op == OP_MULH) || (dec_op == OP_DIV) || (dec_op == OP_REM);
    assign sa       = sgn_a_op && a[XLEN-1];
    assign sb       = sgn_b_op && b[XLEN-1];
    assign mag_a    = sa ? (XLEN'(0) - a) : a;
    assign mag_b    = sb ? (XLEN'(0) - b) : b;
    // Remainder takes the dividend's sign; products and quotients the XOR of both
    assign neg_start = (dec_op == OP_REM) ? sa : (sa ^ sb);

    // Single-cycle results, including divide corner-case fast paths
    logic [XLEN-1:0] base_res;
    always_comb begin
        base_res = '0;
        case (dec_op)
            OP_ADD:  base_res = a + b;
            OP_SUB:  base_res = a - b;
            OP_SLL:  base_res = a << shamt;
            OP_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: base_res = {{(XLEN-1){1'b0}}, a < b};
            OP_XOR:  base_res = a ^ b;
            OP_SRL:  base_res = a >> shamt;
            OP_SRA:  base_res = XLEN'($signed(a) >>> shamt);
            OP_OR:   base_res = a | b;
            OP_AND:  base_res = a & b;
            OP_DIV:  base_res = div_zero ? '1 : XMIN;
            OP_DIVU: base_res = '1;
            OP_REM:  base_res = div_zero ? a : '0;
            OP_REMU: base_res = a;
            default: base_res = '0;
        endcase
    end

    // One iteration step for multiply and divide
    logic [XLEN:0] mul_sum;
    logic [XLEN:0] div_rs;
    logic [XLEN:0] div_diff;
    logic          div_ok;

    assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    assign div_rs   = {hi_q, lo_q[XLEN-1]};
    assign div_diff = div_rs - {1'b0, opnd_q};
    assign div_ok   = !div_diff[XLEN];

    // Sign fix-up and hi/lo or quotient/remainder selection
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_n;
    logic [XLEN-1:0]   quo_n;
    logic [XLEN-1:0]   rem_n;
    logic [XLEN-1:0]   fix_res;

    assign prod   = {hi_q, lo_q};
    assign prod_n = neg_q ? ((2*XLEN)'(0) - prod) : prod;
    assign quo_n  = neg_q ? (XLEN'(0) - lo_q) : lo_q;
    assign rem_n  = neg_q ? (XLEN'(0) - hi_q) : hi_q;

    always_comb begin
        fix_res = rem_n;
        case (op_q)
            OP_MUL:                        fix_res = prod_n[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod_n[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               fix_res = quo_n;
            default:                       fix_res = rem_n;
        endcase
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            busy_q      <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            opnd_q      <= '0;
            cnt_q       <= '0;
            op_q        <= OP_ADD;
            mul_q       <= 1'b0;
            neg_q       <= 1'b0;
        end else if (bus.flush) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (iter_op) begin
                            state_q     <= S_BUSY;
                            busy_q      <= 1'b1;
                            out_valid_q <= 1'b0;
                            cnt_q       <= CW'(XLEN - 1);
                            op_q        <= dec_op;
                            mul_q       <= is_mul;
                            neg_q       <= neg_start;
                            hi_q        <= '0;
                            lo_q        <= is_mul ? mag_b : mag_a;
                            opnd_q      <= is_mul ? mag_a : mag_b;
                        end else begin
                            result_q    <= base_res;
                            zero_q      <= (base_res == '0);
                            out_valid_q <= 1'b1;
                        end
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                S_BUSY: begin
                    if (mul_q) begin
                        {hi_q, lo_q} <= {mul_sum, lo_q[XLEN-1:1]};
                    end else begin
                        hi_q <= div_ok ? div_diff[XLEN-1:0] : div_rs[XLEN-1:0];
                        lo_q <= {lo_q[XLEN-2:0], div_ok};
                    end
                    if (cnt_q == '0) begin
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_FIX: begin
                    result_q    <= fix_res;
                    zero_q      <= (fix_res == '0);
                    out_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_DONE;
                end
                default: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule
